// File: rtl/scoreboard_stall_ctrl.sv
// Per-register countdown scoreboard beside the ID stage: detects read-after-write hazards
// against in-flight producers of variable latency, resolves pipeline stall priority, counts lost cycles.
module scoreboard_stall_ctrl #(
    parameter int NREG    = 32,
    parameter int REGW    = 5,
    parameter int LATW    = 3,
    parameter int PERF_W  = 32,
    parameter int WAW_MAX = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REGW-1:0]   id_rs,
    input  logic [REGW-1:0]   id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_we,
    input  logic [REGW-1:0]   id_rd,
    input  logic [LATW-1:0]   id_lat,
    input  logic              stall_icache,
    input  logic              stall_dcache,
    output logic              stall_IF,
    output logic              stall_ID,
    output logic              bubble_ID,
    output logic              stall_EX,
    output logic              stall_MEM,
    output logic              stall_WB,
    output logic              sb_busy,
    output logic [PERF_W-1:0] perf_haz,
    output logic [PERF_W-1:0] perf_dc
);

    logic [LATW-1:0]   cnt_q [NREG];
    logic [LATW-1:0]   cnt_d [NREG];
    logic [PERF_W-1:0] perf_haz_q;
    logic [PERF_W-1:0] perf_haz_d;
    logic [PERF_W-1:0] perf_dc_q;
    logic [PERF_W-1:0] perf_dc_d;
    logic              haz_s;
    logic              iss_s;

    function automatic logic [LATW-1:0] dec_sat(input logic [LATW-1:0] v);
        return (v != {LATW{1'b0}}) ? (v - {{(LATW-1){1'b0}}, 1'b1}) : {LATW{1'b0}};
    endfunction

    function automatic logic [PERF_W-1:0] inc_sat(input logic [PERF_W-1:0] v);
        return (&v) ? v : (v + {{(PERF_W-1){1'b0}}, 1'b1});
    endfunction

    // Hazard detection: a source is unavailable while its producer's countdown is nonzero.
    always_comb begin
        haz_s = 1'b0;
        if (id_valid) begin
            haz_s = (id_use_rs && (id_rs != {REGW{1'b0}}) && (cnt_q[id_rs] != {LATW{1'b0}})) ||
                    (id_use_rt && (id_rt != {REGW{1'b0}}) && (cnt_q[id_rt] != {LATW{1'b0}}));
        end else begin
            haz_s = 1'b0;
        end
    end

    // Stall priority: D-cache miss freezes everything up to EX, then hazards, then I-cache.
    always_comb begin
        stall_IF  = 1'b0;
        stall_ID  = 1'b0;
        bubble_ID = 1'b0;
        stall_EX  = 1'b0;
        if (stall_dcache) begin
            stall_IF = 1'b1;
            stall_ID = 1'b1;
            stall_EX = 1'b1;
        end else if (haz_s) begin
            stall_IF  = 1'b1;
            stall_ID  = 1'b1;
            bubble_ID = 1'b1;
        end else if (stall_icache) begin
            stall_IF = 1'b1;
        end else begin
            stall_IF = 1'b0;
        end
    end

    assign stall_MEM = 1'b0;
    assign stall_WB  = 1'b0;
    assign iss_s     = id_valid && id_we && (id_rd != {REGW{1'b0}}) && !stall_ID && !bubble_ID;

    // Scoreboard next state: counters freeze with EX, otherwise count down; issuing reloads the destination.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0) begin
                cnt_d[r] = {LATW{1'b0}};
            end else if (stall_EX) begin
                cnt_d[r] = cnt_q[r];
            end else if (iss_s && (id_rd == REGW'(r))) begin
                // WAW: keep the longer outstanding latency so the older producer is still waited for.
                if ((WAW_MAX != 0) && (dec_sat(cnt_q[r]) > id_lat)) begin
                    cnt_d[r] = dec_sat(cnt_q[r]);
                end else begin
                    cnt_d[r] = id_lat;
                end
            end else begin
                cnt_d[r] = dec_sat(cnt_q[r]);
            end
        end
    end

    // Performance counters: hazard cycles only count when not masked by a D-cache stall.
    always_comb begin
        perf_dc_d  = perf_dc_q;
        perf_haz_d = perf_haz_q;
        if (stall_dcache) begin
            perf_dc_d = inc_sat(perf_dc_q);
        end else if (haz_s) begin
            perf_haz_d = inc_sat(perf_haz_q);
        end else begin
            perf_dc_d  = perf_dc_q;
            perf_haz_d = perf_haz_q;
        end
    end

    // State registers with asynchronous clear; pending writes are forgotten on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= {LATW{1'b0}};
            end
            perf_haz_q <= {PERF_W{1'b0}};
            perf_dc_q  <= {PERF_W{1'b0}};
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            perf_haz_q <= perf_haz_d;
            perf_dc_q  <= perf_dc_d;
        end
    end

    // Busy summary reflects the current scoreboard contents.
    always_comb begin
        sb_busy = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            sb_busy = sb_busy | (cnt_q[r] != {LATW{1'b0}});
        end
    end

    assign perf_haz = perf_haz_q;
    assign perf_dc  = perf_dc_q;

endmodule

// File: tb/tb_scoreboard_stall_ctrl.sv
// Bench for scoreboard_stall_ctrl: two instances (WAW_MAX=1/PERF_W=32 and WAW_MAX=0/PERF_W=4)
// share stimulus; expected outputs are queued per cycle and compared by an independent monitor.
module tb_scoreboard_stall_ctrl;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic       rst_n, id_valid, id_use_rs, id_use_rt, id_we, stall_icache, stall_dcache;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [2:0] id_lat;

    logic [1:0]  o_if, o_id, o_bub, o_ex, o_mem, o_wb, o_busy;
    logic [31:0] ph0, pd0;
    logic [3:0]  ph1, pd1;

    scoreboard_stall_ctrl dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_we(id_we), .id_rd(id_rd),
        .id_lat(id_lat), .stall_icache(stall_icache), .stall_dcache(stall_dcache),
        .stall_IF(o_if[0]), .stall_ID(o_id[0]), .bubble_ID(o_bub[0]), .stall_EX(o_ex[0]),
        .stall_MEM(o_mem[0]), .stall_WB(o_wb[0]), .sb_busy(o_busy[0]),
        .perf_haz(ph0), .perf_dc(pd0)
    );

    scoreboard_stall_ctrl #(.WAW_MAX(0), .PERF_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_we(id_we), .id_rd(id_rd),
        .id_lat(id_lat), .stall_icache(stall_icache), .stall_dcache(stall_dcache),
        .stall_IF(o_if[1]), .stall_ID(o_id[1]), .bubble_ID(o_bub[1]), .stall_EX(o_ex[1]),
        .stall_MEM(o_mem[1]), .stall_WB(o_wb[1]), .sb_busy(o_busy[1]),
        .perf_haz(ph1), .perf_dc(pd1)
    );

    typedef struct {
        logic [6:0] ctl;
        longint     ph;
        longint     pd;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    int     m_pend[2][32];
    longint m_ph[2];
    longint m_pd[2];
    longint pmax[2];
    int     tests = 0;
    int     fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each register holds "cycles until forwardable"; a read of a pending
    // register stalls; a D-miss freezes time for the scoreboard.
    task automatic apply(input logic rst, input logic v, input logic urs, input logic urt,
                         input logic we, input logic ic, input logic dc,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [2:0] lat);
        exp_t e;
        rst_n = rst; id_valid = v; id_use_rs = urs; id_use_rt = urt; id_we = we;
        stall_icache = ic; stall_dcache = dc; id_rs = rs; id_rt = rt; id_rd = rd; id_lat = lat;
        if (!rst) begin
            for (int w = 0; w < 2; w++) begin
                for (int r = 0; r < 32; r++) m_pend[w][r] = 0;
                m_ph[w] = 0;
                m_pd[w] = 0;
            end
        end
        for (int w = 0; w < 2; w++) begin
            bit hz, sif, sid, bub, sex, busy, issue;
            hz = v && ((urs && rs != 0 && m_pend[w][rs] > 0) || (urt && rt != 0 && m_pend[w][rt] > 0));
            sif = dc || hz || ic;
            sid = dc || hz;
            bub = !dc && hz;
            sex = dc;
            busy = 0;
            for (int r = 1; r < 32; r++) if (m_pend[w][r] > 0) busy = 1;
            e.ctl = {sif, sid, bub, sex, 1'b0, 1'b0, busy};
            e.ph = m_ph[w];
            e.pd = m_pd[w];
            if (w == 0) q0.push_back(e); else q1.push_back(e);
            if (rst) begin
                issue = v && we && rd != 0 && !sid && !bub;
                if (!sex) begin
                    for (int r = 1; r < 32; r++) begin
                        int left;
                        left = (m_pend[w][r] > 0) ? m_pend[w][r] - 1 : 0;
                        if (issue && r == rd)
                            m_pend[w][r] = (w == 0 && left > int'(lat)) ? left : int'(lat);
                        else
                            m_pend[w][r] = left;
                    end
                end
                if (dc) m_pd[w] = (m_pd[w] < pmax[w]) ? m_pd[w] + 1 : pmax[w];
                else if (hz) m_ph[w] = (m_ph[w] < pmax[w]) ? m_ph[w] + 1 : pmax[w];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'd0);
    endtask

    // Writer: valid, writes rd with latency lat, reads nothing
    task automatic wr(input logic [4:0] rd, input logic [2:0] lat);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, rd, lat);
    endtask

    // Reader: valid, reads rs and rt, writes rd with ALU latency
    task automatic rdr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic dc);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, dc, rs, rt, rd, 3'd0);
    endtask

    // Monitor: compares every presented output cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("ctl_waw_max", 64'({o_if[0], o_id[0], o_bub[0], o_ex[0], o_mem[0], o_wb[0], o_busy[0]}), 64'(e.ctl));
                chk("perf_haz_32", 64'(ph0), 64'(e.ph));
                chk("perf_dc_32", 64'(pd0), 64'(e.pd));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("ctl_waw_ovr", 64'({o_if[1], o_id[1], o_bub[1], o_ex[1], o_mem[1], o_wb[1], o_busy[1]}), 64'(e.ctl));
                chk("perf_haz_4", 64'(ph1), 64'(e.ph));
                chk("perf_dc_4", 64'(pd1), 64'(e.pd));
            end
        end
    end

    initial begin
        pmax[0] = 64'h0000_0000_FFFF_FFFF;
        pmax[1] = 64'd15;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'd0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'd0);
        idle(2);
        // load-use: one bubble
        wr(5'd8, 3'd1);
        rdr(5'd8, 5'd8, 5'd9, 1'b0);
        rdr(5'd8, 5'd8, 5'd9, 1'b0);
        idle(2);
        // multi-cycle producer, then an independent op
        wr(5'd3, 3'd4);
        for (int i = 0; i < 5; i++) rdr(5'd3, 5'd0, 5'd10, 1'b0);
        rdr(5'd11, 5'd12, 5'd13, 1'b0);
        idle(2);
        // D-miss overlapping a load-use hazard
        wr(5'd8, 3'd1);
        for (int i = 0; i < 3; i++) rdr(5'd8, 5'd0, 5'd9, 1'b1);
        rdr(5'd8, 5'd0, 5'd9, 1'b0);
        rdr(5'd8, 5'd0, 5'd9, 1'b0);
        idle(2);
        // WAW on r5, then a reader exposes the surviving count
        wr(5'd5, 3'd4);
        wr(5'd5, 3'd0);
        for (int i = 0; i < 4; i++) rdr(5'd5, 5'd0, 5'd14, 1'b0);
        idle(2);
        // r0 is never tracked; I-cache miss alone
        wr(5'd0, 3'd7);
        rdr(5'd0, 5'd0, 5'd0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 3'd0);
        // reset while r4 is pending, then a dependent goes straight through
        wr(5'd4, 3'd6);
        rdr(5'd4, 5'd0, 5'd15, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 5'd0, 5'd15, 3'd0);
        rdr(5'd4, 5'd0, 5'd15, 1'b0);
        idle(1);
        // randomized traffic over a small register window to provoke hazards and saturation
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 3'($urandom));
        end
        repeat (3) @(negedge clk);
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL drain actual=%0d expected=0 pending expectations", q0.size() + q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
